imm_ext_stage: RTL
==================

// Module: imm_ext_stage
// PURPOSE
//  Decode-stage immediate pipeline stage for the Antares-R2 core: accepts an instruction immediate
//  with an extension mode from the control unit and registers the extended 32-bit operand.
//  The operand goes to the execute stage over a valid/ready handshake.
//  Supports pipeline flush on a taken branch or jump.
//  Sits between the instruction decode logic and the ALU operand mux.
// PARAMETERS
//  IMM_W   16  immediate field width from the instruction word (1..31)
//  DATA_W  32  extended operand width (> IMM_W)
// PORTS
//  clock      in   1       rising-edge clock
//  reset_n    in   1       asynchronous active-low reset
//  in_valid   in   1       upstream immediate and mode are valid
//  in_ready   out  1       stage can accept this cycle
//  in_imm     in   IMM_W   raw immediate field
//  in_mode    in   2       extension mode: 0 SIGN, 1 ZERO, 2 UPPER, 3 BRANCH
//  in_tag     in   5       destination tag carried alongside (rd/rt index)
//  flush      in   1       synchronous kill of every held entry
//  out_valid  out  1       extended operand valid
//  out_ready  in   1       execute stage accepts
//  out_imm    out  DATA_W  extended operand
//  out_tag    out  5       tag of out_imm
//  occupancy  out  2       entries held (0..2)
// BEHAVIOUR
//  Reset (async, reset_n=0): out_valid=0, occupancy=0, out_imm=0, out_tag=0, in_ready=1, all entries cleared.
//  Extension, computed on accept, width DATA_W:
//   - SIGN: replicate in_imm[IMM_W-1].
//   - ZERO: pad with 0.
//   - UPPER: in_imm << (DATA_W-IMM_W), low bits 0.
//   - BRANCH: sign extend, then <<2; bits shifted out are dropped.
//  Transfer rules:
//   - Accept occurs when in_valid&in_ready.
//   - Issue occurs when out_valid&out_ready.
//   - out_imm and out_tag are stable while out_valid=1 and out_ready=0.
//   - Latency: an accepted immediate appears on out_* the next cycle (1 cycle), never the same cycle.
//  FSM on occupancy:
//   - EMPTY: accept -> ONE.
//   - ONE: accept without issue -> TWO; issue without accept -> EMPTY; both -> ONE.
//   - TWO: in_ready=0; issue -> ONE; otherwise stays TWO.
//  Ordering is strict FIFO; the head entry is always on out_*.
//  Flush:
//   - Next state is EMPTY, out_valid=0 the next cycle.
//   - An input offered in the flush cycle is dropped, even if in_ready=1.
//   - An issue in the flush cycle still counts as delivered.
//  Reset mid-transfer discards all entries immediately (async).
//  in_mode values are always legal (2 bits, 4 modes); no error path.
// CONFIGURATION
//  IMM_SKID_EN defined:
//   - Two-entry skid buffer; in_ready = (occupancy<2), fully registered.
//   - No combinational path from out_ready to in_ready.
//   - Sustains 1 transfer per cycle under continuous flow.
//  IMM_SKID_EN undefined:
//   - Single entry; occupancy never exceeds 1; in_ready = ~out_valid | out_ready (combinational).
//   - Throughput is still 1/cycle; TWO state is absent.
// STRUCTURE
//  Shared package antares_pkg:
//   - localparams IMM_MODE_SIGN/ZERO/UPPER/BRANCH (2'd0..3).
//   - DATA_W default.
//   - Tag width constant REG_IDX_W=5.
//  Sub-module imm_extender: combinational (in_imm, in_mode) -> DATA_W operand.
//  The top holds the FSM and entry registers only.
// TESTING
//  1. Single SIGN accept, in_imm=16'h8001, out_ready=1 -> next cycle out_imm=32'hFFFF8001, occupancy 1, then 0.
//  2. Modes on in_imm=16'hF00F:
//     - ZERO -> 32'h0000F00F.
//     - UPPER -> 32'hF00F0000.
//     - BRANCH -> 32'hFFFFC03C.
//  3. out_ready=0, push tags 1,2:
//     - with IMM_SKID_EN: in_ready drops after 2 accepts; out_tag=1 held stable; release -> tags 1,2 in order.
//     - without IMM_SKID_EN: in_ready drops after 1 accept.
//  4. Continuous in_valid=out_ready=1 for 8 items -> 8 issues in 8 cycles after the first, no bubbles.
//  5. occupancy=2 with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, occupancy=0, offered item never issued.
//  6. reset_n pulsed low mid-stream with occupancy=2 -> out_valid=0 immediately, in_ready=1, first post-reset item issues correctly.

Source files
------------

// File: rtl/antares_pkg.sv
// Shared Antares-R2 decode constants: immediate extension modes and operand/tag widths.
package antares_pkg;
  localparam int IMM_W_DEF  = 16;
  localparam int DATA_W_DEF = 32;
  localparam int REG_IDX_W  = 5;

  localparam logic [1:0] IMM_MODE_SIGN   = 2'd0;
  localparam logic [1:0] IMM_MODE_ZERO   = 2'd1;
  localparam logic [1:0] IMM_MODE_UPPER  = 2'd2;
  localparam logic [1:0] IMM_MODE_BRANCH = 2'd3;
endpackage

// File: rtl/imm_ext_stage_if.sv
// Handshake bundle between decode, the immediate stage and execute.
interface imm_ext_stage_if import antares_pkg::*; #(
  parameter int IMM_W  = IMM_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IMM_W-1:0]     in_imm;
  logic [1:0]           in_mode;
  logic [REG_IDX_W-1:0] in_tag;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_imm;
  logic [REG_IDX_W-1:0] out_tag;
  logic [1:0]           occupancy;

  modport master (
    output in_valid, in_imm, in_mode, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, occupancy
  );
  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, flush, out_ready,
    output in_ready, out_valid, out_imm, out_tag, occupancy
  );
endinterface

// File: rtl/imm_extender.sv
// Combinational immediate extender: SIGN / ZERO / UPPER / BRANCH (sign extend then <<2).
module imm_extender import antares_pkg::*; #(
  parameter int IMM_W  = IMM_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [IMM_W-1:0]  imm,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] ext
);
  logic [DATA_W-1:0] sext;
  assign sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

  always_comb begin
    ext = sext;
    case (mode)
      IMM_MODE_SIGN:   ext = sext;
      IMM_MODE_ZERO:   ext = {{(DATA_W-IMM_W){1'b0}}, imm};
      IMM_MODE_UPPER:  ext = {imm, {(DATA_W-IMM_W){1'b0}}};
      IMM_MODE_BRANCH: ext = {sext[DATA_W-3:0], 2'b00};
      default:         ext = sext;
    endcase
  end
endmodule

// File: rtl/imm_ext_stage.sv
// Decode-stage immediate register with valid/ready output and flush.
// IMM_SKID_EN selects a two-entry skid buffer with registered in_ready; otherwise single entry.
module imm_ext_stage import antares_pkg::*; #(
  parameter int IMM_W  = IMM_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic             clock,
  input logic             reset_n,
  imm_ext_stage_if.slave  bus
);
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;

  logic [1:0]           state;
  logic [DATA_W-1:0]    ext;
  logic [DATA_W-1:0]    head_imm;
  logic [REG_IDX_W-1:0] head_tag;
  logic                 acc, iss;

  imm_extender #(.IMM_W(IMM_W), .DATA_W(DATA_W)) u_ext (
    .imm  (bus.in_imm),
    .mode (bus.in_mode),
    .ext  (ext)
  );

  // a flush-cycle offer is dropped regardless of in_ready
  assign acc           = bus.in_valid & bus.in_ready & ~bus.flush;
  assign iss           = bus.out_valid & bus.out_ready;
  assign bus.out_valid = (state != ST_EMPTY);
  assign bus.occupancy = state;
  assign bus.out_imm   = head_imm;
  assign bus.out_tag   = head_tag;

`ifdef IMM_SKID_EN
  localparam logic [1:0] ST_TWO = 2'd2;

  logic [DATA_W-1:0]    skid_imm;
  logic [REG_IDX_W-1:0] skid_tag;

  assign bus.in_ready = (state != ST_TWO);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_EMPTY;
      head_imm <= '0;
      head_tag <= '0;
      skid_imm <= '0;
      skid_tag <= '0;
    end else if (bus.flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (acc) begin
          head_imm <= ext;
          head_tag <= bus.in_tag;
          state    <= ST_ONE;
        end
        ST_ONE: begin
          if (acc && iss) begin
            head_imm <= ext;
            head_tag <= bus.in_tag;
          end else if (acc) begin
            skid_imm <= ext;
            skid_tag <= bus.in_tag;
            state    <= ST_TWO;
          end else if (iss) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: if (iss) begin
          head_imm <= skid_imm;
          head_tag <= skid_tag;
          state    <= ST_ONE;
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end
`else
  assign bus.in_ready = ~bus.out_valid | bus.out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_EMPTY;
      head_imm <= '0;
      head_tag <= '0;
    end else if (bus.flush) begin
      state <= ST_EMPTY;
    end else if (acc) begin
      head_imm <= ext;
      head_tag <= bus.in_tag;
      state    <= ST_ONE;
    end else if (iss) begin
      state <= ST_EMPTY;
    end
  end
`endif
endmodule
